// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : MDUOP/ReadHILO codes, FSM state type and latencies for mul_div_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_BDS   = 4'b1000;
  localparam logic [3:0] OP_MFHL  = 4'b1111;

  localparam logic [1:0] RH_HI = 2'b10;
  localparam logic [1:0] RH_LO = 2'b01;

  localparam int MULT_TIME = 5;
  localparam int DIV_TIME  = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit_if.sv
// ============================================================================
// mul_div_unit_if : E-stage control bundle, operands and HI/LO results
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mul_div_unit_if #(
  parameter int TIME_W = 4
) ();
  logic              Start;
  logic [3:0]        MDUOP;
  logic [TIME_W-1:0] Time;
  logic [31:0]       A;
  logic [31:0]       B;
  logic [1:0]        ReadHILO;
  logic              Busy;
  logic [31:0]       HI;
  logic [31:0]       LO;
  logic [31:0]       MDOut;

  modport master (
    output Start, MDUOP, Time, A, B, ReadHILO,
    input  Busy, HI, LO, MDOut
  );

  modport slave (
    input  Start, MDUOP, Time, A, B, ReadHILO,
    output Busy, HI, LO, MDOut
  );
endinterface

`default_nettype wire

// File: rtl/mdu_compute.sv
// ============================================================================
// mdu_compute : combinational mult/div/BDS datapath (BDS only with MDU_BDS_EN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_compute
  import mdu_pkg::*;
(
  input  logic [3:0]  MDUOP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] resHI,
  output logic [31:0] resLO,
  output logic        valid
);

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_mag_a, w_mag_b, w_divisor;
  logic [31:0]        w_sq, w_sr, w_uq, w_ur;

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes: 0x80000000 / -1 wraps to 0x80000000 with no special case.
  assign w_mag_a   = A[31] ? (~A + 32'd1) : A;
  assign w_mag_b   = B[31] ? (~B + 32'd1) : B;
  assign w_divisor = (B == 32'd0) ? 32'd1 : w_mag_b;
  assign w_sq      = w_mag_a / w_divisor;
  assign w_sr      = w_mag_a % w_divisor;
  assign w_uq      = A / ((B == 32'd0) ? 32'd1 : B);
  assign w_ur      = A % ((B == 32'd0) ? 32'd1 : B);

  always_comb begin
    resHI = '0;
    resLO = '0;
    valid = 1'b0;
    case (MDUOP)
      OP_MULT: begin
        resHI = w_prod_s[63:32];
        resLO = w_prod_s[31:0];
        valid = 1'b1;
      end
      OP_MULTU: begin
        resHI = w_prod_u[63:32];
        resLO = w_prod_u[31:0];
        valid = 1'b1;
      end
      OP_DIV: begin
        resLO = (A[31] ^ B[31]) ? (~w_sq + 32'd1) : w_sq;
        resHI = A[31] ? (~w_sr + 32'd1) : w_sr;
        valid = (B != 32'd0);
      end
      OP_DIVU: begin
        resLO = w_uq;
        resHI = w_ur;
        valid = (B != 32'd0);
      end
`ifdef MDU_BDS_EN
      OP_BDS: begin
        resHI = {26'd0, popcount32(A ^ B)};
        resLO = A ^ B;
        valid = 1'b1;
      end
`endif
      default: valid = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : multi-cycle MIPS HI/LO unit (FSM, latency counter, MDOut mux)
// Optional BDS op enabled by MDU_BDS_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int TIME_W = 4
) (
  input logic          clk,
  input logic          reset,
  mul_div_unit_if.slave bus
);

  state_t            r_state;
  logic [TIME_W-1:0] r_cnt;
  logic [31:0]       r_hi, r_lo, r_res_hi, r_res_lo;
  logic              r_res_valid;
  logic [31:0]       w_res_hi, w_res_lo;
  logic              w_valid;

  mdu_compute u_compute (
    .MDUOP (bus.MDUOP),
    .A     (bus.A),
    .B     (bus.B),
    .resHI (w_res_hi),
    .resLO (w_res_lo),
    .valid (w_valid)
  );

  assign bus.Busy = (r_state == RUN);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

  always_comb begin
    bus.MDOut = '0;
    case (bus.ReadHILO)
      RH_HI:   bus.MDOut = r_hi;
      RH_LO:   bus.MDOut = r_lo;
      default: bus.MDOut = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_res_hi    <= '0;
      r_res_lo    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            if (bus.Time != '0) begin
              r_res_hi    <= w_res_hi;
              r_res_lo    <= w_res_lo;
              r_res_valid <= w_valid;
              r_cnt       <= bus.Time;
              r_state     <= RUN;
            end else if (w_valid) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end else if (bus.MDUOP == OP_MTHI) begin
            r_hi <= bus.A;
          end else if (bus.MDUOP == OP_MTLO) begin
            r_lo <= bus.A;
          end
        end
        RUN: begin
          // The hazard unit must hold off Start and MTHI/MTLO while busy.
          assert (!bus.Start);
          assert (!(bus.MDUOP == OP_MTHI || bus.MDUOP == OP_MTLO));
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == TIME_W'(1)) begin
            if (r_res_valid) begin
              r_hi <= r_res_hi;
              r_lo <= r_res_lo;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// tb_mul_div_unit : directed + random checks of mul_div_unit against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit_if #(.TIME_W(4)) bus ();

  mul_div_unit #(.TIME_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one op, from the instruction-set definition.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
`ifdef MDU_BDS_EN
      4'd8: begin m_hi = 32'($countones(a ^ b)); m_lo = a ^ b; end
`endif
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    bus.Start = 1'b0;
    bus.MDUOP = 4'd0;
    bus.Time  = 4'd0;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle a new op may start.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int t);
    bus.Start = 1'b1; bus.MDUOP = op; bus.A = a; bus.B = b;
    bus.Time = 4'(t); bus.ReadHILO = 2'b10;
    #1 chk("busy_in_start_cycle", {31'd0, bus.Busy}, 32'd0);
    for (int i = 0; i < t; i++) begin
      @(negedge clk);
      if (i == 0) idle_inputs();
      #1;
      chk("busy_running", {31'd0, bus.Busy}, 32'd1);
      chk("mdout_pre_commit", bus.MDOut, m_hi);
    end
    @(negedge clk);
    if (t == 0) idle_inputs();
    model_apply(op, a, b);
    #1;
    chk("busy_done", {31'd0, bus.Busy}, 32'd0);
    chk("hi", bus.HI, m_hi);
    chk("lo", bus.LO, m_lo);
  endtask

  initial begin
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [31:0] a, b;
    logic [1:0] rh;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd0, 4'd9, 4'd15};
    idle_inputs();
    bus.A = '0; bus.B = '0; bus.ReadHILO = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5);
    chk("mult_hi_const", bus.HI, 32'hFFFFFFFF);
    chk("mult_lo_const", bus.LO, 32'hFFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 5);
    chk("multu_mdout", bus.MDOut, 32'h00000002);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10);
    chk("div_lo_const", bus.LO, 32'hFFFFFFFD);
    chk("div_hi_const", bus.HI, 32'hFFFFFFFF);
    run_op(4'd4, 32'd7, 32'd2, 10);
    run_op(4'd3, 32'h12345678, 32'd0, 10);
    chk("div0_hi_kept", bus.HI, 32'd1);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
    chk("div_ovf_lo", bus.LO, 32'h80000000);
    run_op(4'd8, 32'hF0F0F0F0, 32'h0F0F0F0F, 10);
`ifdef MDU_BDS_EN
    chk("bds_hi_const", bus.HI, 32'h20);
`endif

    // MTHI then MTLO on consecutive cycles.
    bus.MDUOP = 4'd5; bus.A = 32'h12345678;
    @(negedge clk);
    bus.MDUOP = 4'd6; bus.A = 32'h9;
    #1 chk("mthi_busy", {31'd0, bus.Busy}, 32'd0);
    chk("mthi_hi", bus.HI, 32'h12345678);
    @(negedge clk);
    bus.MDUOP = 4'd0;
    m_hi = 32'h12345678; m_lo = 32'h9;
    #1 chk("mtlo_busy", {31'd0, bus.Busy}, 32'd0);
    chk("mtlo_lo", bus.LO, 32'h9);

    // Reset in the 3rd busy cycle of a MULT aborts it.
    bus.Start = 1'b1; bus.MDUOP = 4'd1; bus.A = 32'd11; bus.B = 32'd13; bus.Time = 4'd5;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_hi = '0; m_lo = '0;
    #1 chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    @(negedge clk);
    run_op(4'd1, 32'd11, 32'd13, 5);

    // Time=0 immediate commit.
    run_op(4'd2, 32'hDEADBEEF, 32'h10, 0);

    for (int n = 0; n < 30; n++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      run_op(op, a, b, $urandom_range(0, 6));
      rh = 2'($urandom_range(0, 3));
      bus.ReadHILO = rh;
      #1 chk("mdout_sel", bus.MDOut, (rh == 2'b10) ? m_hi : (rh == 2'b01) ? m_lo : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
